// File: rtl/lab4_event_buffer.sv
// LAB4 digitizer event buffer: a ring of sample banks filled one window at a time
// and drained word-pairwise through a two-cycle registered read path.
module lab4_event_buffer #(
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 12,
    parameter int NBANK_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic [SAMPLE_W-1:0]   wr_data,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  rd_avail,
    output logic [NBANK_W-1:0]    rd_bank,
    output logic [ADDR_W:0]       rd_len,
    input  logic                  rd_en,
    input  logic [ADDR_W-2:0]     rd_addr,
    output logic [2*SAMPLE_W-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_done,
    output logic [NBANK_W:0]      full_count,
    output logic [15:0]           ovf_count
);
    localparam int NBANK = 1 << NBANK_W;
    localparam int WORDS = 1 << (NBANK_W + ADDR_W - 1);

    typedef enum logic [1:0] {B_FREE, B_FILL, B_READY} bank_st_t;

    bank_st_t              state_q [NBANK];
    logic [ADDR_W:0]       len_q   [NBANK];
    logic [NBANK_W-1:0]    wbank_q, wbank_d;
    logic [NBANK_W-1:0]    rbank_q, rbank_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [NBANK_W:0]      full_q, full_d;
    logic [15:0]           ovf_q, ovf_d;
    logic                  accept, close, release_bank, rd_fire;
    logic                  s1_v_q, rd_valid_q;
    logic [SAMPLE_W-1:0]   lo_q, hi_q;
    logic [2*SAMPLE_W-1:0] rd_data_q;
    logic [NBANK_W+ADDR_W-2:0] waddr, raddr;

    // Even and odd samples live in separate arrays so one read yields a pair.
    logic [SAMPLE_W-1:0] mem_lo [WORDS];
    logic [SAMPLE_W-1:0] mem_hi [WORDS];

    assign wr_ready      = (state_q[wbank_q] != B_READY);
    assign rd_avail      = (state_q[rbank_q] == B_READY);
    assign rd_bank       = rbank_q;
    assign rd_len        = rd_avail ? len_q[rbank_q] : '0;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign full_count    = full_q;
    assign ovf_count     = ovf_q;

    assign accept       = wr_valid & wr_ready;
    assign close        = accept & (wr_last | (&wr_ptr_q));
    assign release_bank = rd_done & rd_avail;
    assign rd_fire      = rd_en & rd_avail;
    assign waddr        = {wbank_q, wr_ptr_q[ADDR_W-1:1]};
    assign raddr        = {rbank_q, rd_addr};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        if (close) begin
            wr_ptr_d = '0;
            wbank_d  = wbank_q + 1'b1;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (release_bank) begin
            rbank_d = rbank_q + 1'b1;
        end
        case ({close, release_bank})
            2'b10:   full_d = full_q + 1'b1;
            2'b01:   full_d = full_q - 1'b1;
            default: full_d = full_q;
        endcase
        if (wr_valid && !wr_ready && ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NBANK; i++) begin
                state_q[i] <= B_FREE;
                len_q[i]   <= '0;
            end
            wbank_q  <= '0;
            rbank_q  <= '0;
            wr_ptr_q <= '0;
            full_q   <= '0;
            ovf_q    <= '0;
        end else begin
            if (accept) begin
                state_q[wbank_q] <= close ? B_READY : B_FILL;
            end
            if (close) begin
                len_q[wbank_q] <= {1'b0, wr_ptr_q} + 1'b1;
            end
            // Close and release never target the same bank.
            if (release_bank) begin
                state_q[rbank_q] <= B_FREE;
            end
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && rst_n) begin
            if (wr_ptr_q[0]) begin
                mem_hi[waddr] <= wr_data;
            end else begin
                mem_lo[waddr] <= wr_data;
            end
        end
        if (rd_fire) begin
            lo_q <= mem_lo[raddr];
            hi_q <= mem_hi[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_v_q     <= rd_fire;
            rd_valid_q <= s1_v_q;
            if (s1_v_q) begin
                rd_data_q <= {hi_q, lo_q};
            end
        end
    end
endmodule

// File: tb/tb_lab4_event_buffer.sv
// Bench for lab4_event_buffer: directed scenarios plus a randomized run
// against a window-queue reference model.
module tb_lab4_event_buffer;
    localparam int SW = 12;
    localparam int AW = 4;
    localparam int NW = 2;
    localparam int NB = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_valid = 1'b0;
    logic wr_last = 1'b0;
    logic rd_en = 1'b0;
    logic rd_done = 1'b0;
    logic [SW-1:0] wr_data = '0;
    logic [AW-2:0] rd_addr = '0;
    logic wr_ready, rd_avail, rd_data_valid;
    logic [NW-1:0] rd_bank;
    logic [AW:0] rd_len;
    logic [2*SW-1:0] rd_data;
    logic [NW:0] full_count;
    logic [15:0] ovf_count;

    int checks = 0;
    int errors = 0;

    lab4_event_buffer #(.SAMPLE_W(SW), .ADDR_W(AW), .NBANK_W(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .rd_avail(rd_avail), .rd_bank(rd_bank),
        .rd_len(rd_len), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_done(rd_done), .full_count(full_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Reference model: closed windows queue up oldest-first; reads look at the front.
    logic [SW-1:0] wsamp [256][DEPTH];
    int wlen [256];
    int ready_q [$];
    int cur_win, cur_n, releases, m_ovf;
    bit p_v, p_c, e_v, e_c;
    logic [2*SW-1:0] p_d, e_d;

    task automatic m_reset();
        ready_q.delete();
        cur_win = 0; cur_n = 0; releases = 0; m_ovf = 0;
        p_v = 0; p_c = 1; p_d = '0;
        e_v = 0; e_c = 1; e_d = '0;
    endtask

    task automatic step();
        bit room;
        int k, f;
        room = (ready_q.size() < NB);
        e_v = p_v; e_c = p_c; e_d = p_d;
        if (!rst_n) begin
            m_reset();
        end else begin
            p_v = 0; p_c = 0; p_d = '0;
            if (rd_en && ready_q.size() > 0) begin
                f = ready_q[0];
                k = int'(rd_addr);
                p_v = 1;
                if (2 * k + 1 < wlen[f]) begin
                    p_c = 1;
                    p_d = {wsamp[f][2*k+1], wsamp[f][2*k]};
                end
            end
            if (rd_done && ready_q.size() > 0) begin
                void'(ready_q.pop_front());
                releases++;
            end
            if (wr_valid) begin
                if (room) begin
                    wsamp[cur_win][cur_n] = wr_data;
                    cur_n++;
                    if (wr_last || cur_n == DEPTH) begin
                        wlen[cur_win] = cur_n;
                        ready_q.push_back(cur_win);
                        cur_win = (cur_win + 1) % 256;
                        cur_n = 0;
                    end
                end else if (m_ovf < 65535) begin
                    m_ovf++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; wr_last = 0; rd_en = 0; rd_done = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic wr(input logic [SW-1:0] d, input bit last);
        wr_valid = 1; wr_data = d; wr_last = last;
        step();
        wr_valid = 0; wr_last = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL rst_rd_avail got=%b exp=0", rd_avail); end
        checks++; if (full_count !== 3'd0) begin errors++; $display("FAIL rst_full got=%0d exp=0", full_count); end
        checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL rst_ovf got=%0d exp=0", ovf_count); end
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rd_data_valid); end
        checks++; if (rd_data !== 24'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", rd_data); end
        checks++; if (rd_len !== 5'd0) begin errors++; $display("FAIL rst_len got=%0d exp=0", rd_len); end
        checks++; if (rd_bank !== 2'd0) begin errors++; $display("FAIL rst_bank got=%0d exp=0", rd_bank); end
    endtask

    task automatic test_full_bank();
        logic [2*SW-1:0] exp_w;
        do_reset();
        for (int i = 1; i <= 16; i++) wr(SW'(i), 0);
        checks++; if (full_count !== 3'd1) begin errors++; $display("FAIL fb_full got=%0d exp=1", full_count); end
        checks++; if (rd_avail !== 1'b1) begin errors++; $display("FAIL fb_avail got=%b exp=1", rd_avail); end
        checks++; if (rd_len !== 5'd16) begin errors++; $display("FAIL fb_len got=%0d exp=16", rd_len); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fb_wr_ready got=%b exp=1", wr_ready); end
        for (int k = 0; k <= 8; k++) begin
            rd_en = (k < 8);
            rd_addr = (AW-1)'(k);
            step();
            if (k == 0) begin
                checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL fb_early_valid got=%b exp=0", rd_data_valid); end
            end else begin
                exp_w = {SW'(2 * k), SW'(2 * k - 1)};
                checks++; if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL fb_valid w%0d got=%b exp=1", k - 1, rd_data_valid); end
                checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL fb_data w%0d got=%h exp=%h", k - 1, rd_data, exp_w); end
            end
        end
        idle();
    endtask

    task automatic test_last();
        do_reset();
        for (int i = 1; i <= 5; i++) wr(SW'(12'h100 + i), i == 5);
        checks++; if (rd_len !== 5'd5) begin errors++; $display("FAIL last_len got=%0d exp=5", rd_len); end
        checks++; if (full_count !== 3'd1) begin errors++; $display("FAIL last_full got=%0d exp=1", full_count); end
        wr(12'h5A5, 1);
        checks++; if (full_count !== 3'd2) begin errors++; $display("FAIL last_full2 got=%0d exp=2", full_count); end
        rd_done = 1;
        step();
        rd_done = 0;
        checks++; if (rd_bank !== 2'd1) begin errors++; $display("FAIL last_bank got=%0d exp=1", rd_bank); end
        checks++; if (rd_len !== 5'd1) begin errors++; $display("FAIL last_len1 got=%0d exp=1", rd_len); end
        rd_en = 1; rd_addr = '0;
        step();
        rd_en = 0;
        step();
        checks++; if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL last_valid got=%b exp=1", rd_data_valid); end
        checks++; if (rd_data[SW-1:0] !== 12'h5A5) begin errors++; $display("FAIL last_b1a0 got=%h exp=5a5", rd_data[SW-1:0]); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < b + 2; i++) wr(SW'(12'h200 + b * 16 + i), i == b + 1);
        checks++; if (full_count !== 3'd4) begin errors++; $display("FAIL ovf_full4 got=%0d exp=4", full_count); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready0 got=%b exp=0", wr_ready); end
        for (int i = 0; i < 3; i++) wr(12'hEEE, 0);
        checks++; if (ovf_count !== 16'd3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", ovf_count); end
        checks++; if (full_count !== 3'd4) begin errors++; $display("FAIL ovf_full got=%0d exp=4", full_count); end
        rd_done = 1;
        step();
        rd_done = 0;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready1 got=%b exp=1", wr_ready); end
        checks++; if (full_count !== 3'd3) begin errors++; $display("FAIL ovf_full3 got=%0d exp=3", full_count); end
        rd_en = 1; rd_addr = '0;
        step();
        rd_en = 0;
        step();
        checks++; if (rd_data !== 24'h211210) begin errors++; $display("FAIL ovf_data got=%h exp=211210", rd_data); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        wr(12'h011, 0);
        wr(12'h012, 1);
        wr(12'h021, 0);
        wr_valid = 1; wr_data = 12'h022; wr_last = 1; rd_done = 1;
        step();
        idle();
        checks++; if (full_count !== 3'd1) begin errors++; $display("FAIL same_full got=%0d exp=1", full_count); end
        checks++; if (rd_bank !== 2'd1) begin errors++; $display("FAIL same_bank got=%0d exp=1", rd_bank); end
        checks++; if (rd_len !== 5'd2) begin errors++; $display("FAIL same_len got=%0d exp=2", rd_len); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 4; i++) wr(SW'(12'h0A0 + i), i == 4);
        rd_en = 1; rd_addr = 3'd0;
        step();
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_v0 got=%b exp=0", rd_data_valid); end
        rd_addr = 3'd1; rd_done = 1;
        step();
        rd_done = 0; rd_addr = 3'd0;
        checks++; if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL b2b_v1 got=%b exp=1", rd_data_valid); end
        checks++; if (rd_data !== 24'h0A20A1) begin errors++; $display("FAIL b2b_d1 got=%h exp=0a20a1", rd_data); end
        checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL b2b_avail got=%b exp=0", rd_avail); end
        step();
        rd_en = 0;
        checks++; if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL b2b_v2 got=%b exp=1", rd_data_valid); end
        checks++; if (rd_data !== 24'h0A40A3) begin errors++; $display("FAIL b2b_d2 got=%h exp=0a40a3", rd_data); end
        step();
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_ignored got=%b exp=0", rd_data_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int b = 0; b < 4; b++) wr(SW'(12'h300 + b), 1);
        wr(12'h3FF, 0);
        wr(12'h3FE, 0);
        rd_en = 1; rd_addr = '0;
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        rd_en = 0;
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", rd_data_valid); end
        checks++; if (full_count !== 3'd0) begin errors++; $display("FAIL mid_full got=%0d exp=0", full_count); end
        checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL mid_ovf got=%0d exp=0", ovf_count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", wr_ready); end
        checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL mid_avail got=%b exp=0", rd_avail); end
        step();
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL mid_flight got=%b exp=0", rd_data_valid); end
    endtask

    task automatic test_random();
        logic [AW:0] exp_len;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 499) != 0);
            wr_valid = ($urandom_range(0, 9) < 6);
            wr_last  = ($urandom_range(0, 6) == 0);
            wr_data  = SW'($urandom);
            rd_en    = ($urandom_range(0, 1) == 1);
            rd_addr  = (AW-1)'($urandom);
            rd_done  = ($urandom_range(0, 11) == 0);
            step();
            exp_len = (ready_q.size() > 0) ? (AW+1)'(wlen[ready_q[0]]) : '0;
            checks++; if (wr_ready !== (ready_q.size() < NB)) begin errors++; $display("FAIL rnd_ready n=%0d got=%b", n, wr_ready); end
            checks++; if (rd_avail !== (ready_q.size() > 0)) begin errors++; $display("FAIL rnd_avail n=%0d got=%b", n, rd_avail); end
            checks++; if (full_count !== (NW+1)'(ready_q.size())) begin errors++; $display("FAIL rnd_full n=%0d got=%0d exp=%0d", n, full_count, ready_q.size()); end
            checks++; if (rd_bank !== NW'(releases % NB)) begin errors++; $display("FAIL rnd_bank n=%0d got=%0d exp=%0d", n, rd_bank, releases % NB); end
            checks++; if (rd_len !== exp_len) begin errors++; $display("FAIL rnd_len n=%0d got=%0d exp=%0d", n, rd_len, exp_len); end
            checks++; if (ovf_count !== 16'(m_ovf)) begin errors++; $display("FAIL rnd_ovf n=%0d got=%0d exp=%0d", n, ovf_count, m_ovf); end
            checks++; if (rd_data_valid !== e_v) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, rd_data_valid, e_v); end
            if (e_c) begin
                checks++; if (rd_data !== e_d) begin errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, rd_data, e_d); end
            end
        end
        idle();
        rst_n = 1;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_full_bank();
        test_last();
        test_overflow();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lab4_event_buffer.md
LAB4_EVENT_BUFFER -- requirements
Module: lab4_event_buffer

Interface
REQ-001 Parameter SAMPLE_W, 12, bits per LAB4 sample.
REQ-002 Parameter ADDR_W, 12, log2 samples per bank (>=2); bank holds 2^ADDR_W samples.
REQ-003 Parameter NBANK_W, 2, log2 bank count; 2^NBANK_W banks in a ring.
REQ-004 Port clk  in  1  sole clock; all logic and memory on rising edge.
REQ-005 Port rst_n  in  1  reset; synchronous and active-low.
REQ-006 Port wr_valid  in  1  sample present.
REQ-007 Port wr_data  in  SAMPLE_W  sample.
REQ-008 Port wr_last  in  1  final sample of window; qualified by wr_valid.
REQ-009 Port wr_ready  out  1  current write bank can accept.
REQ-010 Port rd_avail  out  1  oldest bank is READY.
REQ-011 Port rd_bank  out  NBANK_W  index of oldest bank.
REQ-012 Port rd_len  out  ADDR_W+1  sample count of oldest READY bank.
REQ-013 Port rd_en  in  1  read request.
REQ-014 Port rd_addr  in  ADDR_W-1  word address in oldest bank.
REQ-015 Port rd_data  out  2*SAMPLE_W  {sample 2k+1, sample 2k}.
REQ-016 Port rd_data_valid  out  1  rd_data qualifier.
REQ-017 Port rd_done  in  1  release oldest bank.
REQ-018 Port full_count  out  NBANK_W+1  number of READY banks.
REQ-019 Port ovf_count  out  16  dropped-sample counter.

Function
REQ-020 Each bank SHALL have state FREE, FILL or READY; wbank and rbank pointers SHALL wrap modulo 2^NBANK_W.
REQ-021 wr_ready SHALL be high iff state[wbank] != READY, derived from registered state only.
REQ-022 Accept = wr_valid & wr_ready; accepted sample SHALL be written at {wbank, wr_ptr}, wr_ptr incremented, bank FREE->FILL.
REQ-023 Bank SHALL close (->READY, length latched = wr_ptr+1, wbank++, wr_ptr=0) on accepted wr_last or on accepting sample 2^ADDR_W-1; both together close once.
REQ-024 wr_valid & !wr_ready SHALL drop the sample and increment ovf_count, saturating at 16'hFFFF.
REQ-025 rd_avail = (state[rbank]==READY); rd_len and rd_bank reflect rbank; rd_len SHALL read 0 when !rd_avail.
REQ-026 rd_en & rd_avail SHALL produce rd_data_valid exactly 2 cycles later (BRAM + output register), fully pipelined, one word per cycle.
REQ-027 rd_en while !rd_avail SHALL be ignored (no rd_data_valid).
REQ-028 Words beyond rd_len SHALL return unspecified data but still assert rd_data_valid.
REQ-029 rd_done & rd_avail SHALL set state[rbank]=FREE and rbank++; rd_done while !rd_avail ignored.
REQ-030 Reads already in the 2-cycle pipeline at rd_done SHALL still complete with that bank's data.
REQ-031 Same-cycle bank close and rd_done SHALL both take effect; full_count unchanged net.
REQ-032 A bank freed by rd_done SHALL be writable from the next cycle (wr_ready rises one cycle later).
REQ-033 full_count SHALL equal count of READY banks every cycle, range 0..2^NBANK_W.

Reset
REQ-034 rst_n low at clk edge: all banks FREE, wbank=rbank=0, wr_ptr=0, ovf_count=0, full_count=0, rd_data=0, rd_data_valid=0, in-flight reads discarded.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Reset mid-fill or mid-read SHALL abandon the window; post-reset wr_ready=1, rd_avail=0.

Verification
REQ-037 ADDR_W=4: write 16 samples 0x001..0x010, no wr_last -> bank 0 READY, rd_len=16, rd_addr 0..7 return {0x002,0x001}..{0x010,0x00F}, valid 2 cycles after each rd_en.
REQ-038 Write 5 samples with wr_last on 5th -> rd_len=5, full_count=1, next sample lands in bank 1 address 0.
REQ-039 NBANK_W=2: fill 4 banks, push 3 more samples -> wr_ready=0, ovf_count=3, full_count=4; rd_done -> wr_ready=1 next cycle.
REQ-040 Close bank 1 in same cycle as rd_done on bank 0 -> full_count unchanged, rbank=1.
REQ-041 Back-to-back rd_en then rd_done in the next cycle -> both words valid with bank-0 data; rd_en with rd_avail=0 -> no valid.
REQ-042 Drive rst_n low 1 cycle mid-read with reads in flight -> rd_data_valid=0 next cycle, all counters 0, wr_ready=1.
